tag_ram_nway: RTL and testbench

TAG_RAM_NWAY -- requirements
Module: tag_ram_nway

---
 rtl/tag_ram_nway.sv | 146 ++++++++++++++
 tb/tb_tag_ram_nway.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_ram_nway.sv
`default_nettype none
// ============================================================================
// Module      : tag_ram_nway
// Description : N-way set-associative tag RAM with MSI state, 1-cycle lookup
//               and a self-invalidating init/clear sweep.
// Revision    : 1.0  initial release
// ============================================================================
module tag_ram_nway #(
    parameter int AWIDTH      = 3,
    parameter int TWIDTH      = 11,
    parameter int NWAYS       = 2,
    parameter int WRITE_FIRST = 0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     lookup_valid,
    input  logic [AWIDTH-1:0]        lookup_addr,
    input  logic [TWIDTH-1:0]        lookup_tag,
    input  logic                     wr_en,
    input  logic [NWAYS-1:0]         wr_way,
    input  logic [AWIDTH-1:0]        wr_addr,
    input  logic [TWIDTH-1:0]        wr_tag,
    input  logic [1:0]               wr_state,
    input  logic                     clear,
    output logic                     busy,
    output logic                     rsp_valid,
    output logic                     hit,
    output logic [NWAYS-1:0]         hit_way,
    output logic                     multi_hit,
    output logic [NWAYS*TWIDTH-1:0]  rd_tag,
    output logic [NWAYS*2-1:0]       rd_state
);

    localparam int                c_depth    = 2**AWIDTH;
    localparam int                c_ew       = TWIDTH + 2;
    localparam logic [AWIDTH-1:0] c_last_idx = AWIDTH'(c_depth - 1);

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                 r_state;
    logic [AWIDTH-1:0]      r_cnt;
    logic                   r_busy;

    logic                   w_wr_fire;
    logic                   w_lk_fire;
    logic [c_ew-1:0]        w_wr_entry;
    logic [NWAYS-1:0][c_ew-1:0] w_rd_entry;
    logic [NWAYS-1:0]       w_match;

    logic                   r_rsp_valid;
    logic                   r_hit;
    logic [NWAYS-1:0]       r_hit_way;
    logic                   r_multi_hit;
    logic [NWAYS*TWIDTH-1:0] r_rd_tag;
    logic [NWAYS*2-1:0]     r_rd_state;

    // Requests arriving during the sweep are dropped, not queued.
    assign w_wr_fire  = wr_en & ~r_busy;
    assign w_lk_fire  = lookup_valid & ~r_busy;
    assign w_wr_entry = {wr_state, wr_tag};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                SWEEP: begin
                    r_cnt <= r_cnt + AWIDTH'(1);
                    if (r_cnt == c_last_idx) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NWAYS; g++) begin : g_way
            logic [c_ew-1:0] r_mem [c_depth];
            logic            w_bypass;
            logic [1:0]      w_st;

            // Storage is never reset; the sweep invalidates it instead.
            always_ff @(posedge clock) begin
                if (r_busy) begin
                    r_mem[r_cnt] <= '0;
                end else if (w_wr_fire && wr_way[g]) begin
                    r_mem[wr_addr] <= w_wr_entry;
                end
            end

            assign w_bypass = (WRITE_FIRST != 0) && w_wr_fire && wr_way[g]
                              && (wr_addr == lookup_addr);
            assign w_rd_entry[g] = w_bypass ? w_wr_entry : r_mem[lookup_addr];
            assign w_st          = w_rd_entry[g][TWIDTH +: 2];
            // Only S (01) and M (10) are valid; I and reserved never hit.
            assign w_match[g]    = (w_st[0] ^ w_st[1])
                                   && (w_rd_entry[g][TWIDTH-1:0] == lookup_tag);
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_hit_way   <= '0;
            r_multi_hit <= 1'b0;
            r_rd_tag    <= '0;
            r_rd_state  <= '0;
        end else begin
            r_rsp_valid <= w_lk_fire;
            if (w_lk_fire) begin
                r_hit       <= |w_match;
                r_hit_way   <= w_match;
                r_multi_hit <= |(w_match & (w_match - NWAYS'(1)));
                for (int w = 0; w < NWAYS; w++) begin
                    r_rd_tag[w*TWIDTH +: TWIDTH] <= w_rd_entry[w][TWIDTH-1:0];
                    r_rd_state[w*2 +: 2]         <= w_rd_entry[w][TWIDTH +: 2];
                end
            end
        end
    end

    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign hit       = r_hit;
    assign hit_way   = r_hit_way;
    assign multi_hit = r_multi_hit;
    assign rd_tag    = r_rd_tag;
    assign rd_state  = r_rd_state;

endmodule
`default_nettype wire

// File: tb/tb_tag_ram_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_ram_nway
// Description : Vector table + scoreboard bench for tag_ram_nway, both
//               collision modes side by side.
// Revision    : 1.0  initial release
// ============================================================================
module tb_tag_ram_nway;

    typedef struct {
        bit        lv;
        bit [2:0]  la;
        bit [10:0] lt;
        bit        we;
        bit [1:0]  ww;
        bit [2:0]  wa;
        bit [10:0] wt;
        bit [1:0]  ws;
        bit [1:0]  way0;
        bit [3:0]  st0;
        bit [1:0]  way1;
        bit [3:0]  st1;
        bit        chk_tag;
        bit [10:0] tag0;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        lookup_valid, wr_en, clear;
    logic [2:0]  lookup_addr, wr_addr;
    logic [10:0] lookup_tag, wr_tag;
    logic [1:0]  wr_way, wr_state;

    logic        busy0, rsp_valid0, hit0, multi0;
    logic [1:0]  hit_way0;
    logic [21:0] rd_tag0;
    logic [3:0]  rd_state0;
    logic        busy1, rsp_valid1, hit1, multi1;
    logic [1:0]  hit_way1;
    logic [21:0] rd_tag1;
    logic [3:0]  rd_state1;

    int   total = 0;
    int   bad = 0;
    int   n_busy;
    vec_t q[$];
    vec_t e;
    vec_t tbl[15];
    logic [1:0] last_way0 = '0, last_way1 = '0;
    logic [3:0] last_st0 = '0, last_st1 = '0;

    always #5 clock = ~clock;

    tag_ram_nway #(.AWIDTH(3), .TWIDTH(11), .NWAYS(2), .WRITE_FIRST(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_tag(lookup_tag),
        .wr_en(wr_en), .wr_way(wr_way), .wr_addr(wr_addr), .wr_tag(wr_tag),
        .wr_state(wr_state), .clear(clear),
        .busy(busy0), .rsp_valid(rsp_valid0), .hit(hit0), .hit_way(hit_way0),
        .multi_hit(multi0), .rd_tag(rd_tag0), .rd_state(rd_state0)
    );

    tag_ram_nway #(.AWIDTH(3), .TWIDTH(11), .NWAYS(2), .WRITE_FIRST(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .lookup_valid(lookup_valid), .lookup_addr(lookup_addr), .lookup_tag(lookup_tag),
        .wr_en(wr_en), .wr_way(wr_way), .wr_addr(wr_addr), .wr_tag(wr_tag),
        .wr_state(wr_state), .clear(clear),
        .busy(busy1), .rsp_valid(rsp_valid1), .hit(hit1), .hit_way(hit_way1),
        .multi_hit(multi1), .rd_tag(rd_tag1), .rd_state(rd_state1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        lookup_valid = 0; lookup_addr = 0; lookup_tag = 0;
        wr_en = 0; wr_way = 0; wr_addr = 0; wr_tag = 0; wr_state = 0; clear = 0;
    endtask

    task automatic apply(input vec_t v);
        lookup_valid = v.lv; lookup_addr = v.la; lookup_tag = v.lt;
        wr_en = v.we; wr_way = v.ww; wr_addr = v.wa; wr_tag = v.wt; wr_state = v.ws;
        if (v.lv) q.push_back(v);
        @(posedge clock);
        #1;
        idle_inputs();
    endtask

    task automatic lookup_miss(input bit [2:0] a, input bit [10:0] t);
        apply('{1, a, t, 0, 0, 0, 0, 0, 2'b00, 4'b0000, 2'b00, 4'b0000, 0, 0});
    endtask

    // Counts negedges with busy high; waits briefly for busy to rise first.
    task automatic count_busy(output int n);
        n = 0;
        @(negedge clock);
        for (int i = 0; i < 4 && !busy0; i++) @(negedge clock);
        while (busy0 && n < 40) begin
            n++;
            @(negedge clock);
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            last_way0 = '0; last_st0 = '0; last_way1 = '0; last_st1 = '0;
        end else begin
            chk("rsp_valid_wf1", rsp_valid1, rsp_valid0);
            if (rsp_valid0) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected 0 at %0t", $time);
                    last_way0 = hit_way0; last_st0 = rd_state0;
                    last_way1 = hit_way1; last_st1 = rd_state1;
                end else begin
                    e = q.pop_front();
                    chk("hit_wf0",      hit0,      |e.way0);
                    chk("hit_way_wf0",  hit_way0,  e.way0);
                    chk("multi_wf0",    multi0,    e.way0 == 2'b11);
                    chk("rd_state_wf0", rd_state0, e.st0);
                    chk("hit_wf1",      hit1,      |e.way1);
                    chk("hit_way_wf1",  hit_way1,  e.way1);
                    chk("multi_wf1",    multi1,    e.way1 == 2'b11);
                    chk("rd_state_wf1", rd_state1, e.st1);
                    if (e.chk_tag) begin
                        chk("rd_tag0_wf0", rd_tag0[10:0], e.tag0);
                        chk("rd_tag0_wf1", rd_tag1[10:0], e.tag0);
                    end
                    last_way0 = e.way0; last_st0 = e.st0;
                    last_way1 = e.way1; last_st1 = e.st1;
                end
            end else begin
                chk("hold_way_wf0",   hit_way0,  last_way0);
                chk("hold_state_wf0", rd_state0, last_st0);
                chk("hold_way_wf1",   hit_way1,  last_way1);
                chk("hold_state_wf1", rd_state1, last_st1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //        lv la lt       we ww     wa wt       ws     way0   st0      way1   st1      ct tag0
        tbl[0]  = '{1, 0, 11'h0AA, 0, 2'b00, 0, 11'h000, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 0, 0};
        tbl[1]  = '{1, 7, 11'h7FF, 0, 2'b00, 0, 11'h000, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 0, 0};
        tbl[2]  = '{0, 0, 11'h000, 1, 2'b01, 5, 11'h2A3, 2'b01, 2'b00, 4'b0000, 2'b00, 4'b0000, 0, 0};
        tbl[3]  = '{1, 5, 11'h2A3, 0, 2'b00, 0, 11'h000, 2'b00, 2'b01, 4'b0001, 2'b01, 4'b0001, 1, 11'h2A3};
        tbl[4]  = '{1, 5, 11'h2A4, 0, 2'b00, 0, 11'h000, 2'b00, 2'b00, 4'b0001, 2'b00, 4'b0001, 1, 11'h2A3};
        tbl[5]  = '{0, 0, 11'h000, 1, 2'b11, 2, 11'h011, 2'b10, 2'b00, 4'b0000, 2'b00, 4'b0000, 0, 0};
        tbl[6]  = '{1, 2, 11'h011, 0, 2'b00, 0, 11'h000, 2'b00, 2'b11, 4'b1010, 2'b11, 4'b1010, 1, 11'h011};
        tbl[7]  = '{1, 2, 11'h011, 1, 2'b10, 5, 11'h2A3, 2'b11, 2'b11, 4'b1010, 2'b11, 4'b1010, 1, 11'h011};
        tbl[8]  = '{1, 5, 11'h2A3, 0, 2'b00, 0, 11'h000, 2'b00, 2'b01, 4'b1101, 2'b01, 4'b1101, 1, 11'h2A3};
        tbl[9]  = '{1, 3, 11'h100, 1, 2'b01, 3, 11'h100, 2'b01, 2'b00, 4'b0000, 2'b01, 4'b0001, 0, 0};
        tbl[10] = '{1, 3, 11'h100, 0, 2'b00, 0, 11'h000, 2'b00, 2'b01, 4'b0001, 2'b01, 4'b0001, 1, 11'h100};
        tbl[11] = '{0, 0, 11'h000, 1, 2'b00, 6, 11'h055, 2'b01, 2'b00, 4'b0000, 2'b00, 4'b0000, 0, 0};
        tbl[12] = '{1, 6, 11'h055, 0, 2'b00, 0, 11'h000, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 0, 0};
        tbl[13] = '{1, 3, 11'h100, 1, 2'b10, 3, 11'h100, 2'b10, 2'b01, 4'b0001, 2'b11, 4'b1001, 1, 11'h100};
        tbl[14] = '{1, 3, 11'h100, 0, 2'b00, 0, 11'h000, 2'b00, 2'b11, 4'b1001, 2'b11, 4'b1001, 1, 11'h100};

        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_busy",      busy0,      1);
        chk("reset_busy_wf1",  busy1,      1);
        chk("reset_rsp_valid", rsp_valid0, 0);
        chk("reset_hit",       hit0,       0);
        chk("reset_hit_way",   hit_way0,   0);
        chk("reset_multi",     multi0,     0);
        chk("reset_rd_tag",    rd_tag0,    0);
        chk("reset_rd_state",  rd_state0,  0);

        // Release reset while hammering writes/lookups that must be dropped.
        @(posedge clock);
        #1;
        reset_n = 1;
        fork
            count_busy(n_busy);
            begin
                wr_en = 1; wr_way = 2'b11; wr_addr = 0; wr_tag = 11'h0AA; wr_state = 2'b01;
                lookup_valid = 1; lookup_addr = 0; lookup_tag = 11'h0AA;
                repeat (8) @(posedge clock);
                #1;
                idle_inputs();
            end
        join
        chk("init_sweep_cycles", n_busy, 8);

        for (int i = 0; i < 15; i++) apply(tbl[i]);

        // Clear sweep: ops dropped, a second clear mid-sweep is ignored.
        fork
            count_busy(n_busy);
            begin
                clear = 1;
                @(posedge clock);
                #1;
                clear = 0;
                wr_en = 1; wr_way = 2'b11; wr_addr = 4; wr_tag = 11'h1F0; wr_state = 2'b01;
                lookup_valid = 1; lookup_addr = 4; lookup_tag = 11'h1F0;
                repeat (2) begin @(posedge clock); #1; end
                clear = 1;
                @(posedge clock);
                #1;
                clear = 0;
                repeat (3) begin @(posedge clock); #1; end
                idle_inputs();
            end
        join
        chk("clear_sweep_cycles", n_busy, 8);
        lookup_miss(5, 11'h2A3);
        lookup_miss(2, 11'h011);
        lookup_miss(3, 11'h100);
        lookup_miss(4, 11'h1F0);

        // Reset asserted at sweep index 4 aborts and restarts the sweep.
        apply('{0, 0, 11'h000, 1, 2'b01, 1, 11'h123, 2'b01, 2'b00, 4'b0000, 2'b00, 4'b0000, 0, 0});
        apply('{1, 1, 11'h123, 0, 2'b00, 0, 11'h000, 2'b00, 2'b01, 4'b0001, 2'b01, 4'b0001, 1, 11'h123});
        clear = 1;
        @(posedge clock);
        #1;
        clear = 0;
        repeat (4) @(posedge clock);
        #1;
        chk("hit_held_in_sweep", hit0, 1);
        reset_n = 0;
        #1;
        chk("midsweep_rst_busy",     busy0,      1);
        chk("midsweep_rst_rsp",      rsp_valid0, 0);
        chk("midsweep_rst_hit",      hit0,       0);
        chk("midsweep_rst_hit_way",  hit_way0,   0);
        chk("midsweep_rst_multi",    multi0,     0);
        chk("midsweep_rst_rd_tag",   rd_tag0,    0);
        chk("midsweep_rst_rd_state", rd_state0,  0);
        chk("midsweep_rst_hit_wf1",  hit_way1,   0);
        @(posedge clock);
        #1;
        reset_n = 1;
        count_busy(n_busy);
        chk("restart_sweep_cycles", n_busy, 8);
        lookup_miss(1, 11'h123);

        repeat (2) @(negedge clock);
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
